// File: rtl/rf_write_arbiter.sv
// Purpose: owns the register file write port. Zeroes registers 1..NUM_REGS-1 after reset or clear_req,
//          then arbitrates NUM_REQ writers: requester 0 (ROB commit) has priority, secondaries are round-robin with a starvation override.
// Latency: 1 cycle from valid&ready to rf_we/rf_waddr/rf_wdata. Backpressure: requests hold until the one-hot req_ready grants them.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   clear_req         single-cycle pulse, restarts the zeroing sweep
//   req_valid/addr/data  per-requester write requests (addr/data packed, requester i at [i*W +: W])
//   req_ready         one-hot combinational grant
//   rf_we/waddr/wdata registered register-file write port
//   grant_id          registered index of the requester behind the current write (0 during sweep)
//   init_done         high while arbitration is active
module rf_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_REGS   = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_req,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        init_done
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [SW-1:0]     SMAX      = SW'(STARVE_MAX);

    typedef enum logic {ST_INIT, ST_ARB} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  sweep_cnt;
    logic [GW-1:0]      rr_ptr;
    logic [SW-1:0]      starve_cnt [NUM_REQ];

    logic               active;
    logic [NUM_REQ-1:0] starved;
    logic [NUM_REQ-1:0] sec_valid;
    logic [GW:0]        pick_starved;
    logic [GW:0]        pick_valid;
    logic               gnt_found;
    logic [GW-1:0]      gnt_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    // Round-robin search over secondaries 1..NUM_REQ-1 starting at ptr.
    // Returns {found, index}. Descending loop so the candidate closest to ptr is assigned last and wins.
    function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] cand, input logic [GW-1:0] ptr);
        logic [GW:0] res;
        int          idx;
        res = '0;
        for (int k = NUM_REQ - 2; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx > NUM_REQ - 1) idx = idx - (NUM_REQ - 1);
            if (cand[GW'(idx)]) res = {1'b1, GW'(idx)};
        end
        return res;
    endfunction

    // Arbitration only runs once the post-sweep idle cycle has passed (init_done high),
    // so the first ARB cycle always drives rf_we low.
    always_comb begin
        active    = (state == ST_ARB) && init_done && !clear_req;
        sec_valid = {req_valid[NUM_REQ-1:1], 1'b0};
        starved   = '0;
        for (int j = 1; j < NUM_REQ; j++) begin
            starved[j] = req_valid[j] && (starve_cnt[j] == SMAX);
        end
        pick_starved = rr_pick(starved, rr_ptr);
        pick_valid   = rr_pick(sec_valid, rr_ptr);

        gnt_found = 1'b0;
        gnt_idx   = '0;
        if (active) begin
            if (pick_starved[GW]) begin
                gnt_found = 1'b1;
                gnt_idx   = pick_starved[GW-1:0];
            end else if (req_valid[0]) begin
                gnt_found = 1'b1;
                gnt_idx   = '0;
            end else if (pick_valid[GW]) begin
                gnt_found = 1'b1;
                gnt_idx   = pick_valid[GW-1:0];
            end
        end

        req_ready = '0;
        if (gnt_found) req_ready[gnt_idx] = 1'b1;

        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(gnt_idx)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear_req) begin
            state_nxt = ST_INIT;
        end else if (state == ST_INIT && sweep_cnt == LAST_ADDR) begin
            state_nxt = ST_ARB;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_cnt <= ADDR_W'(1);
            rr_ptr    <= GW'(1);
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            grant_id  <= '0;
            init_done <= 1'b0;
            for (int j = 0; j < NUM_REQ; j++) starve_cnt[j] <= '0;
        end else if (clear_req) begin
            sweep_cnt <= ADDR_W'(1);
            rr_ptr    <= GW'(1);
            rf_we     <= 1'b0;
            init_done <= 1'b0;
            for (int j = 0; j < NUM_REQ; j++) starve_cnt[j] <= '0;
        end else if (state == ST_INIT) begin
            rf_we     <= 1'b1;
            rf_waddr  <= sweep_cnt;
            rf_wdata  <= '0;
            grant_id  <= '0;
            sweep_cnt <= sweep_cnt + ADDR_W'(1);
        end else if (!init_done) begin
            rf_we     <= 1'b0;
            init_done <= 1'b1;
        end else begin
            if (gnt_found) begin
                // Address 0 is hardwired; the request is acknowledged but never written.
                rf_we    <= (sel_addr != '0);
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                grant_id <= gnt_idx;
                if (gnt_idx != '0) begin
                    rr_ptr <= (gnt_idx == GW'(NUM_REQ - 1)) ? GW'(1) : gnt_idx + GW'(1);
                end
            end else begin
                rf_we <= 1'b0;
            end
            for (int j = 1; j < NUM_REQ; j++) begin
                if (!req_valid[j] || req_ready[j]) begin
                    starve_cnt[j] <= '0;
                end else if (starve_cnt[j] != SMAX) begin
                    starve_cnt[j] <= starve_cnt[j] + SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Purpose: directed bench for rf_write_arbiter: sweep, priority, round-robin, starvation, addr 0, clear, mid-sweep reset.
// Latency: expects 1-cycle accept-to-write. Backpressure: drives valid until the cycle req_ready is seen.
// Inputs change on the falling edge; outputs are sampled on the falling edge or just after it.
module tb_rf_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    logic                       clk;
    logic                       rst;
    logic                       clear_req;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       rf_we;
    logic [ADDR_W-1:0]          rf_waddr;
    logic [DATA_W-1:0]          rf_wdata;
    logic [1:0]                 grant_id;
    logic                       init_done;

    int n_cmp = 0;
    int n_err = 0;

    rf_write_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .grant_id(grant_id), .init_done(init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Starting at a falling edge whose following rising edge presents address 1:
    // 31 consecutive zero writes to 1..31 with req_ready low, then an idle cycle with init_done high.
    task automatic sweep_expect(input string tag);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== 32'h0 ||
                req_ready !== 3'b000 || init_done !== 1'b0) begin
                n_err++;
                $display("FAIL %s_sweep_%0d: we=%b addr=%0d data=%h ready=%b done=%b, want we=1 addr=%0d data=0 ready=000 done=0",
                         tag, k, rf_we, rf_waddr, rf_wdata, req_ready, init_done, k);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0 || init_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_sweep_end: we=%b done=%b, want we=0 done=1", tag, rf_we, init_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_req = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || grant_id !== 2'd0 ||
            init_done !== 1'b0 || req_ready !== 3'b000) begin
            n_err++;
            $display("FAIL reset_state: we=%b addr=%0d data=%h gid=%0d done=%b ready=%b, want all 0",
                     rf_we, rf_waddr, rf_wdata, grant_id, init_done, req_ready);
        end
        rst = 1'b1;
    endtask

    task automatic test_init_sweep();
        sweep_expect("init");
    endtask

    task automatic test_single_write();
        req_valid = 3'b001;
        req_addr[0*ADDR_W +: ADDR_W] = 5'd7;
        req_data[0*DATA_W +: DATA_W] = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (req_ready !== 3'b001) begin
            n_err++;
            $display("FAIL single_ready: got %b want 001", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF || grant_id !== 2'd0) begin
            n_err++;
            $display("FAIL single_write: we=%b addr=%0d data=%h gid=%0d, want 1 7 deadbeef 0",
                     rf_we, rf_waddr, rf_wdata, grant_id);
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rdy [4];
        logic [1:0] exp_gid [4];
        exp_rdy = '{3'b010, 3'b100, 3'b010, 3'b100};
        exp_gid = '{2'd1, 2'd2, 2'd1, 2'd2};
        @(negedge clk);
        req_valid = 3'b110;
        req_addr[1*ADDR_W +: ADDR_W] = 5'd1;  req_data[1*DATA_W +: DATA_W] = 32'hA1A1A1A1;
        req_addr[2*ADDR_W +: ADDR_W] = 5'd2;  req_data[2*DATA_W +: DATA_W] = 32'hA2A2A2A2;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (req_ready !== exp_rdy[c]) begin
                n_err++;
                $display("FAIL rr_ready_%0d: got %b want %b", c, req_ready, exp_rdy[c]);
            end
            @(negedge clk);
            n_cmp++;
            if (grant_id !== exp_gid[c] || rf_we !== 1'b1 || rf_waddr !== 5'(exp_gid[c])) begin
                n_err++;
                $display("FAIL rr_grant_%0d: gid=%0d we=%b addr=%0d, want gid=%0d we=1 addr=%0d",
                         c, grant_id, rf_we, rf_waddr, exp_gid[c], exp_gid[c]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_starvation();
        logic [2:0] exp_rdy [6];
        exp_rdy = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
        @(negedge clk);
        req_valid = 3'b011;
        req_addr[0*ADDR_W +: ADDR_W] = 5'd3;  req_data[0*DATA_W +: DATA_W] = 32'h00000003;
        req_addr[1*ADDR_W +: ADDR_W] = 5'd4;  req_data[1*DATA_W +: DATA_W] = 32'h00000004;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if (req_ready !== exp_rdy[c]) begin
                n_err++;
                $display("FAIL starve_ready_%0d: got %b want %b", c, req_ready, exp_rdy[c]);
            end
            @(negedge clk);
            n_cmp++;
            if (grant_id !== ((c == 4) ? 2'd1 : 2'd0) || rf_waddr !== ((c == 4) ? 5'd4 : 5'd3)) begin
                n_err++;
                $display("FAIL starve_grant_%0d: gid=%0d addr=%0d, want gid=%0d", c, grant_id, rf_waddr,
                         (c == 4) ? 1 : 0);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_addr_zero();
        @(negedge clk);
        req_valid = 3'b100;
        req_addr[2*ADDR_W +: ADDR_W] = 5'd0;
        req_data[2*DATA_W +: DATA_W] = 32'h00001234;
        #1;
        n_cmp++;
        if (req_ready !== 3'b100) begin
            n_err++;
            $display("FAIL addr0_ready: got %b want 100", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0 || grant_id !== 2'd2 || rf_wdata !== 32'h00001234) begin
            n_err++;
            $display("FAIL addr0_write: we=%b gid=%0d data=%h, want we=0 gid=2 data=00001234",
                     rf_we, grant_id, rf_wdata);
        end
        req_valid = '0;
    endtask

    task automatic test_clear();
        @(negedge clk);
        req_valid = 3'b001;
        req_addr[0*ADDR_W +: ADDR_W] = 5'd9;
        req_data[0*DATA_W +: DATA_W] = 32'h000055AA;
        clear_req = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 3'b000 || init_done !== 1'b1) begin
            n_err++;
            $display("FAIL clear_cycle: ready=%b done=%b, want ready=000 done=1", req_ready, init_done);
        end
        @(negedge clk);
        clear_req = 1'b0;
        n_cmp++;
        if (init_done !== 1'b0 || rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL clear_after: done=%b we=%b, want 0 0", init_done, rf_we);
        end
        sweep_expect("clear");
        #1;
        n_cmp++;
        if (req_ready !== 3'b001) begin
            n_err++;
            $display("FAIL clear_pending_ready: got %b want 001", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h000055AA || grant_id !== 2'd0) begin
            n_err++;
            $display("FAIL clear_pending_write: we=%b addr=%0d data=%h gid=%0d, want 1 9 000055aa 0",
                     rf_we, rf_waddr, rf_wdata, grant_id);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd12) begin
            n_err++;
            $display("FAIL midreset_pre: we=%b addr=%0d, want we=1 addr=12", rf_we, rf_waddr);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || grant_id !== 2'd0 ||
            init_done !== 1'b0 || req_ready !== 3'b000) begin
            n_err++;
            $display("FAIL midreset_async: we=%b addr=%0d data=%h gid=%0d done=%b ready=%b, want all 0",
                     rf_we, rf_waddr, rf_wdata, grant_id, init_done, req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        sweep_expect("midreset");
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_single_write();
        test_round_robin();
        test_starvation();
        test_addr_zero();
        test_clear();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the register file's single write port (we/waddr/wdata) and shares it between NUM_REQ writers.
- Requester 0 is ROB commit and has priority. Requesters 1..NUM_REQ-1 are secondary writers (debug, CSR side effects) and are served round-robin.
- After reset or on clear_req, runs a sweep that writes zero to every architectural register. This gives a clean state without relying on the file's own reset.
- Outputs are registered and drive the register file directly.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8).
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, registers swept during init (address 0 is never written).
- STARVE_MAX, 4, consecutive lost cycles after which a waiting secondary requester beats requester 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clear_req  in  1  single-cycle pulse; restart the zeroing sweep.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data; same packing as req_addr.
- req_ready  out  NUM_REQ  one-hot grant, combinational; a transfer occurs when valid&ready.
- rf_we  out  1  register file write enable, registered.
- rf_waddr  out  ADDR_W  registered write address.
- rf_wdata  out  DATA_W  registered write data.
- grant_id  out  $clog2(NUM_REQ)  registered index of the requester behind the current rf_we; 0 during sweep.
- init_done  out  1  high when arbitration is active.

Behaviour:
- Reset (rst=0, asynchronous) clears state and outputs:
  - state=INIT, sweep_cnt=1, rr_ptr=1, all starve counters 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, init_done=0, req_ready=0.
- INIT state:
  - req_ready=0.
  - On each edge: rf_we<=1, rf_waddr<=sweep_cnt, rf_wdata<=0, then sweep_cnt increments.
  - The edge that presents address NUM_REGS-1 also moves state to ARB.
  - On the next edge: rf_we<=0, init_done<=1.
  - Result: exactly NUM_REGS-1 writes (addresses 1..31), on consecutive cycles.
- ARB state:
  - At most one req_ready bit high per cycle.
  - Default: requester 0 wins whenever req_valid[0]=1.
  - Override: if some secondary requester j has starve_cnt[j]==STARVE_MAX, the round-robin winner among the starved requesters wins instead.
  - Round-robin order starts at rr_ptr and wraps over 1..NUM_REQ-1.
  - ready depends only on valid and internal state, never on ready of other requesters.
- Accept (valid&ready for requester g), on the next edge:
  - rf_we<=(addr!=0), rf_waddr<=addr, rf_wdata<=data, grant_id<=g.
  - Latency is 1 cycle.
  - A write to address 0 is consumed and acknowledged, but rf_we stays 0.
- No accept in a cycle: rf_we<=0; rf_waddr, rf_wdata and grant_id hold.
- rr_ptr: after a secondary grant to j, rr_ptr<=j+1, wrapping to 1. A grant to requester 0 leaves it unchanged.
- Starvation counters, per secondary j:
  - Increment (saturate at STARVE_MAX) when valid and not granted.
  - Clear when granted or when valid=0.
- clear_req:
  - Has priority over arbitration: req_ready=0 in the cycle it is high.
  - Next edge: state=INIT, sweep_cnt=1, init_done=0, rf_we=0, counters cleared, rr_ptr=1.
  - In INIT it restarts the sweep at address 1.
  - A write already registered on the output completes normally.
- Requesters must hold valid/addr/data stable until accepted. The block never drops a valid request in ARB except during a clear_req cycle, when it is not accepted.

Test Plan:
- Release rst; hold requests idle -> rf_we high 31 consecutive cycles, rf_waddr 1..31, rf_wdata 0; init_done=1 on the following cycle; req_ready=0 throughout the sweep.
- After init, req_valid=3'b001, addr=7, data=0xDEADBEEF -> req_ready[0]=1 that cycle; next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF, grant_id=0.
- Requesters 1 and 2 valid continuously, requester 0 idle -> grants alternate 1,2,1,2; rr_ptr wraps correctly.
- Requesters 0 and 1 valid continuously, STARVE_MAX=4 -> requester 0 granted 4 cycles, requester 1 on the 5th, then requester 0 resumes.
- Requester 2 writes addr 0, data 0x1234 -> req_ready[2]=1, next cycle rf_we=0.
- clear_req pulsed with req_valid[0]=1 in ARB -> req_ready=0 that cycle; init_done falls; a fresh 31-write sweep runs from address 1; then the pending request is accepted.
- Assert rst mid-sweep at address 12 -> outputs immediately 0; after release the sweep restarts at address 1.
